// File: rtl/digit_entry_ctrl.sv
// Digit entry front end: synchronizes SW/ENTER, debounces ENTER, strobes one digit per press.
// Optional INVALID_REJECT_EN: reject digits above 9 with a digit_err strobe instead of accepting them.
//
// state      | meaning
// S_IDLE     | button released, waiting for a low sample
// S_DB_PRESS | counting consecutive low samples
// S_HELD     | press accepted, waiting for release
// S_DB_REL   | counting consecutive high samples
module digit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       enter_n,
    input  logic       clear,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       digit_err,
    output logic [2:0] digit_idx,
    output logic       seq_done,
    output logic [3:0] live_digit
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DB_PRESS, S_HELD, S_DB_REL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_done;
    logic [3:0]    sw_m, sw_s;
    logic          key_m, key_s;
    logic          accept, bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_m  <= 4'd0;
            sw_s  <= 4'd0;
            key_m <= 1'b1;
            key_s <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            key_m <= enter_n;
            key_s <= key_m;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        press_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!key_s) begin
                    state_nxt = S_DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            S_DB_PRESS: begin
                if (key_s) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = S_HELD;
                    press_done = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (key_s) begin
                    state_nxt = S_DB_REL;
                    cnt_nxt   = '0;
                end
            end
            S_DB_REL: begin
                if (!key_s) begin
                    state_nxt = S_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A full sequence swallows presses; the FSM keeps tracking so nothing replays after clear.
    assign accept = press_done && !seq_done;

`ifdef INVALID_REJECT_EN
    assign bad = (sw_s > 4'd9);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) digit_err <= 1'b0;
        else          digit_err <= accept && bad && !clear;
    end
`else
    assign bad       = 1'b0;
    assign digit_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            digit_idx   <= 3'd0;
        end else begin
            digit_valid <= accept && !bad && !clear;
            if (accept && !bad) digit <= sw_s;
            if (clear)                digit_idx <= 3'd0;
            else if (accept && !bad)  digit_idx <= digit_idx + 3'd1;
        end
    end

    assign seq_done   = (digit_idx == 3'(NUM_DIGITS));
    assign live_digit = sw_s;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Scoreboard bench for digit_entry_ctrl: presses push expected strobes, a monitor pops and checks them.
module tb_digit_entry_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sw;
    logic       enter_n;
    logic       clear;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_err;
    logic [2:0] digit_idx;
    logic       seq_done;
    logic [3:0] live_digit;

    digit_entry_ctrl #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(6)) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .enter_n(enter_n), .clear(clear),
        .digit(digit), .digit_valid(digit_valid), .digit_err(digit_err),
        .digit_idx(digit_idx), .seq_done(seq_done), .live_digit(live_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [3:0] dig;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   strobes = 0;
    int   exp_strobes = 0;
    int   model_idx = 0;
    logic [3:0] model_digit = 4'd0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (digit_valid || digit_err)) begin
                strobes++;
                chk("strobe_exclusive", int'(digit_valid && digit_err), 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got valid=%0b err=%0b digit=%0d expected no strobe",
                             digit_valid, digit_err, digit);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind_err", int'(digit_err), int'(e.err));
                    chk("strobe_digit", int'(digit), int'(e.dig));
                    chk("strobe_idx", int'(digit_idx), int'(e.idx));
                end
            end
        end
    endtask

    function automatic logic is_bad(input logic [3:0] v);
`ifdef INVALID_REJECT_EN
        return v > 4'd9;
`else
        return 1'b0;
`endif
    endfunction

    task automatic expect_press(input logic [3:0] v);
        exp_t e;
        if (model_idx < 6) begin
            if (is_bad(v)) begin
                e.err = 1'b1; e.dig = model_digit; e.idx = 3'(model_idx);
            end else begin
                model_idx++;
                model_digit = v;
                e.err = 1'b0; e.dig = v; e.idx = 3'(model_idx);
            end
            exp_q.push_back(e);
            exp_strobes++;
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        sw = v;
        repeat (3) @(negedge clk);
        expect_press(v);
        enter_n = 1'b0;
        repeat (hold) @(negedge clk);
        enter_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_idx = 0;
        chk("clear_idx", int'(digit_idx), 0);
        chk("clear_seq_done", int'(seq_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        exp_t e;
        logic [3:0] seq[6] = '{4'd6, 4'd9, 4'd3, 4'd0, 4'd0, 4'd2};

        reset_n = 1'b0; enter_n = 1'b0; sw = 4'd5; clear = 1'b0;
        fork monitor_loop(); join_none
        repeat (3) @(negedge clk);
        chk("rst_digit", int'(digit), 0);
        chk("rst_valid", int'(digit_valid), 0);
        chk("rst_err", int'(digit_err), 0);
        chk("rst_idx", int'(digit_idx), 0);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_live", int'(live_digit), 0);

        // Button held through reset: first strobe at rising edge 7 after release.
        expect_press(4'd5);
        reset_n = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (digit_valid) break;
        end
        chk("reset_latency_edges", n, 7);
        chk("live_digit", int'(live_digit), 5);
        @(negedge clk);
        enter_n = 1'b1;
        repeat (10) @(negedge clk);
        do_clear();

        // Bounce: low 2, high 1, then steady low.
        sw = 4'd3;
        repeat (3) @(negedge clk);
        s0 = strobes;
        enter_n = 1'b0;
        repeat (2) @(negedge clk);
        enter_n = 1'b1;
        @(negedge clk);
        enter_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("bounce_no_early_strobe", strobes, s0);
        expect_press(4'd3);
        repeat (10) @(negedge clk);
        enter_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("bounce_one_strobe", strobes, s0 + 1);
        do_clear();

        for (int i = 0; i < 6; i++) begin
            press(seq[i], 10);
            chk("seq_idx", int'(digit_idx), i + 1);
        end
        chk("seq_done_full", int'(seq_done), 1);
        press(4'd5, 10);
        chk("full_digit_held", int'(digit), 2);
        chk("full_idx_held", int'(digit_idx), 6);
        do_clear();

        // Clear landing on the accept edge.
        press(4'd1, 10);
        sw = 4'd4;
        repeat (3) @(negedge clk);
        s0 = strobes;
        enter_n = 1'b0;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_idx = 0;
        model_digit = 4'd4;
        chk("race_no_strobe", strobes, s0);
        chk("race_idx", int'(digit_idx), 0);
        chk("race_seq_done", int'(seq_done), 0);
        chk("race_digit", int'(digit), 4);
        enter_n = 1'b1;
        repeat (8) @(negedge clk);

        press(4'hA, 10);
`ifdef INVALID_REJECT_EN
        chk("invalid_idx", int'(digit_idx), 0);
        chk("invalid_digit", int'(digit), 4);
`else
        chk("invalid_idx", int'(digit_idx), 1);
        chk("invalid_digit", int'(digit), 10);
`endif

        s0 = strobes;
        press(4'd8, 50);
        chk("hold_one_strobe", strobes, s0 + 1);
        press(4'd7, 10);
        chk("hold_second_digit", int'(digit), 7);
        chk("hold_second_idx", int'(digit_idx), model_idx);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("strobe_count", strobes, exp_strobes);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
